// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-reg mux, optional write forwarding, ready.
// Forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              pend_bit,
  input  logic              busy,
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  logic zero;
  logic byp;

  assign zero = (ZERO_REG != 0) && (addr == '0);

`ifdef REGFILE_BYPASS_EN
  assign byp = wr_valid && (addr == wr_addr);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    data = arr_data;
    unique case (1'b1)
      zero:    data = '0;
`ifdef REGFILE_BYPASS_EN
      byp:     data = wr_data;
`endif
      default: data = arr_data;
    endcase
  end

  assign ready = ~busy & (zero | byp | ~pend_bit);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with pending bits and a sequential clear engine.
// Define REGFILE_BYPASS_EN to forward the writeback value to matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_ready,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    mark_en,
  input  logic [ADDR_W-1:0]       mark_addr,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS-1);

  rf_state_t         state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic              idle;
  logic              wr_ok;
  logic              mk_ok;

  assign idle     = (state == RF_IDLE);
  assign clr_busy = (state == RF_CLEAR);
  assign wr_ok = idle && wr_en
              && !((ZERO_REG != 0) && (wr_addr == '0));
  assign mk_ok = idle && mark_en
              && !((ZERO_REG != 0) && (mark_addr == '0));

  always_comb begin
    state_n = state;
    unique case (state)
      RF_IDLE:  if (clr_req) state_n = RF_CLEAR;
      RF_CLEAR: if (cnt == LAST) state_n = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (clr_busy) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Mark is applied after the write so it wins on an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend <= '0;
    end else if (clr_busy) begin
      regs[cnt] <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      if (mk_ok) pend[mark_addr] <= 1'b1;
    end
  end

  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0))
                  ? '0 : regs[dbg_addr];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .addr    (a),
      .arr_data(regs[a]),
      .pend_bit(pend[a]),
      .busy    (clr_busy),
`ifdef REGFILE_BYPASS_EN
      .wr_valid(wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
`endif
      .data    (rd_data[i*DATA_W +: DATA_W]),
      .ready   (rd_ready[i])
    );
  end

endmodule
